// File: rtl/router_pkt_src.sv
`default_nettype none
// router_pkt_src: header/payload/parity packet generator for the router fabric.
// Rev 1.0 - initial release.
module router_pkt_src #(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 2,
  parameter int              LEN_W     = 6,
  parameter int              NUM_DEST  = 3,
  parameter logic [DATA_W-1:0] LFSR_SEED = 8'hA5,
  parameter int              GAP_CYC   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest,
  input  logic [LEN_W-1:0]  len,
  input  logic              bad_parity,
  input  logic              busy,
  output logic              packet_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              active,
  output logic              done,
  output logic              cfg_err,
  output logic [15:0]       pkt_cnt
);

  // Right-shift Galois masks: bit k-1 set for each x^k term of the polynomial.
  // Widths not listed fall back to a non-maximal mask.
  function automatic logic [63:0] taps_for(input int w);
    case (w)
      3:       taps_for = 64'h6;
      4:       taps_for = 64'hC;
      5:       taps_for = 64'h14;
      6:       taps_for = 64'h30;
      7:       taps_for = 64'h60;
      8:       taps_for = 64'hB8;
      9:       taps_for = 64'h110;
      10:      taps_for = 64'h240;
      11:      taps_for = 64'h500;
      12:      taps_for = 64'hE08;
      13:      taps_for = 64'h1C80;
      14:      taps_for = 64'h3802;
      15:      taps_for = 64'h6000;
      16:      taps_for = 64'hD008;
      24:      taps_for = 64'hE10000;
      32:      taps_for = 64'h8020_0003;
      default: taps_for = (64'd1 << (w - 1)) | 64'd1;
    endcase
  endfunction

  localparam logic [63:0]       TAPS_ALL = taps_for(DATA_W);
  localparam logic [DATA_W-1:0] TAPS     = TAPS_ALL[DATA_W-1:0];
  localparam int                GAP_W    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [ADDR_W:0]   NUM_DEST_C = (ADDR_W + 1)'(NUM_DEST);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  lfsr;
  logic [DATA_W-1:0]  acc;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   word_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               bad_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      lfsr         <= LFSR_SEED;
      acc          <= '0;
      len_q        <= '0;
      word_cnt     <= '0;
      gap_cnt      <= '0;
      bad_q        <= 1'b0;
      packet_valid <= 1'b0;
      data_out     <= '0;
      active       <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (({1'b0, dest} < NUM_DEST_C) && (len != '0)) begin
              len_q        <= len;
              bad_q        <= bad_parity;
              data_out     <= {len, dest};
              acc          <= {len, dest};
              packet_valid <= 1'b1;
              active       <= 1'b1;
              state        <= S_HEADER;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_HEADER, S_PAYLOAD: begin
          if (!busy) begin
            if (state == S_HEADER || word_cnt < len_q) begin
              data_out <= lfsr;
              acc      <= acc ^ lfsr;
              lfsr     <= {1'b0, lfsr[DATA_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
              word_cnt <= (state == S_HEADER) ? LEN_W'(1) : word_cnt + LEN_W'(1);
              state    <= S_PAYLOAD;
            end else begin
              data_out     <= acc ^ {{(DATA_W-1){1'b0}}, bad_q};
              packet_valid <= 1'b0;
              state        <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            done     <= 1'b1;
            pkt_cnt  <= pkt_cnt + 16'd1;
            data_out <= '0;
            gap_cnt  <= GAP_W'(GAP_CYC);
            if (GAP_CYC == 0) begin
              active <= 1'b0;
              state  <= S_IDLE;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          // The parity-accept cycle already counts as the first gap cycle.
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            active  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Synthesizable, parametrised packet source for the router fabric.
- Produces header/payload/parity packets on the router input interface (`packet_valid`, `data_in`) and honours the router's `busy` back-pressure.
- Generalises to any data width, address width and destination count, with a pseudo-random payload, error injection and an inter-packet gap.
- Used for on-chip self-test and as the standard stimulus source for router benches.

Parameters:
- DATA_W, 8, width of every packet word.
- ADDR_W, 2, width of the destination field in the header. DATA_W = LEN_W + ADDR_W is required.
- LEN_W, 6, width of the payload-length field in the header.
- NUM_DEST, 3, number of valid destinations. Legal dest values are 0..NUM_DEST-1.
- LFSR_SEED, 8'hA5, reset and reload value of the payload LFSR. Nonzero, DATA_W bits.
- GAP_CYC, 4, idle cycles inserted after each parity word before the next start is accepted (0 allowed).

Ports:
- clk  in  1  clock, rising-edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request one packet; sampled in IDLE only.
- dest  in  ADDR_W  destination for the requested packet.
- len  in  LEN_W  payload word count for the requested packet.
- bad_parity  in  1  when high with start, the parity word is sent with bit 0 inverted.
- busy  in  1  router back-pressure; stalls the source.
- packet_valid  out  1  high during header and payload words.
- data_out  out  DATA_W  packet word, to router data_in.
- active  out  1  high from start acceptance until GAP completes.
- done  out  1  one-cycle pulse when the parity word is accepted.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- pkt_cnt  out  16  completed-packet count; wraps 16'hFFFF -> 0.

Behaviour:
- Reset: asynchronous; immediate regardless of state.
  - packet_valid, data_out, active, done, cfg_err and pkt_cnt are all 0.
  - state = IDLE, LFSR = LFSR_SEED.
  - Reset mid-packet drops packet_valid immediately; no parity word is sent.
- All outputs are registered.
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - start=1 with dest<NUM_DEST and len!=0 at edge N:
    - latch dest, len and bad_parity;
    - data_out <= {len,dest}, packet_valid <= 1, active <= 1;
    - parity accumulator <= header; state -> HEADER.
    - Header is visible in cycle N+1.
  - start=1 with dest>=NUM_DEST or len==0: cfg_err pulses 1 cycle, state stays IDLE, nothing driven.
  - start=0: hold.
- A word is "accepted" at a rising edge where busy=0 in HEADER, PAYLOAD or PARITY. With busy=1 everything holds: data_out, packet_valid, state, counters, LFSR, accumulator.
- HEADER, header accepted:
  - data_out <= LFSR, accumulator ^= LFSR;
  - LFSR advances one step;
  - word counter <= 1; state -> PAYLOAD.
- PAYLOAD, word accepted:
  - if counter < len: next LFSR word as above, counter++.
  - if counter == len:
    - data_out <= accumulator ^ {{DATA_W-1{0}}, bad_parity_latched};
    - packet_valid <= 0; state -> PARITY.
- PARITY, parity word accepted:
  - done pulses;
  - pkt_cnt++;
  - data_out <= 0;
  - gap counter <= GAP_CYC; state -> GAP. If GAP_CYC=0, state goes directly to IDLE and active <= 0.
- GAP: counter decrements each cycle; at 0, state -> IDLE and active <= 0. start is ignored in GAP.
- start outside IDLE is ignored; no cfg_err.
- LFSR:
  - Galois, maximal-length polynomial per DATA_W; for 8 it is x^8+x^6+x^5+x^4+1.
  - Advances only on accepted payload words.
  - Not reloaded between packets, so the sequence continues across packets.
- Packet length on the wire is len+2 accepted words: header, len payload words, parity.

Test Plan:
- Reset, then start with dest=1, len=1, busy=0 → header 8'h05, payload 8'hA5 (packet_valid=1 on both), parity 8'hA0 with packet_valid=0; done at the parity edge; pkt_cnt=1; active falls after 4 gap cycles.
- dest=2, len=14, busy=0 → header 8'h3A, 14 payload words starting 8'hA5, parity equals XOR of all 15 prior words; 16 wire words total.
- Same as the first case with bad_parity=1 → parity 8'hA1.
- busy asserted for 3 cycles during payload word 2 → data_out and packet_valid are stable for all 3 cycles; the sequence then resumes without any word lost or duplicated.
- start with dest=3 (NUM_DEST=3), then with len=0 → cfg_err pulses once each; packet_valid stays 0; pkt_cnt unchanged. A start pulsed during GAP is ignored.
- resetn low mid-payload → packet_valid is 0 asynchronously and the LFSR is reseeded; the next packet's first payload is 8'hA5.
